// File: rtl/bcd_tens_tracker.sv
// bcd_tens_tracker: tens digit for a single-digit up/down BCD units counter.
//   Samples the units digit {A,B,C,D} every clock and infers the step direction
//   from the digit transition. Together with the units digit, tens forms a
//   two-digit 00-99 up/down count.
//   clk  : rising-edge clock, shared with the units counter
//   rst  : synchronous active-high reset
//   A..D : units BCD digit, A = MSB
//   tens : tens BCD digit, 0-9, lags the units digit by one clock
//   ovf  : one-cycle pulse after a 99->00 or 00->99 wrap
//   err  : sticky flag for a non-BCD units code or a non-adjacent units jump
//   trk  : high while a valid previous units sample is held
module bcd_tens_tracker (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   output logic [3:0] tens,
   output logic       ovf,
   output logic       err,
   output logic       trk
);
   typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;
   state_t     state_q, state_d;
   logic [3:0] prev_q, prev_d, tens_q, tens_d, u, up_nxt, dn_nxt;
   logic       ovf_q, ovf_d;
   always_comb begin
      u       = {A, B, C, D};
      up_nxt  = (prev_q == 4'd9) ? 4'd0 : prev_q + 4'd1;
      dn_nxt  = (prev_q == 4'd0) ? 4'd9 : prev_q - 4'd1;
      state_d = state_q;
      prev_d  = prev_q;
      tens_d  = tens_q;
      ovf_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (u > 4'd9) begin
               state_d = ERROR;
            end else begin
               prev_d  = u;
               state_d = TRACK;
            end
         end
         TRACK: begin
            if (u > 4'd9) begin
               state_d = ERROR;
            end else if (u == prev_q) begin
               state_d = TRACK;
            end else if (u == up_nxt) begin
               prev_d = u;
               // units 9->0 carries into tens
               if (prev_q == 4'd9) begin
                  tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
                  ovf_d  = (tens_q == 4'd9);
               end
            end else if (u == dn_nxt) begin
               prev_d = u;
               // units 0->9 borrows from tens
               if (prev_q == 4'd0) begin
                  tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
                  ovf_d  = (tens_q == 4'd0);
               end
            end else begin
               state_d = ERROR;
            end
         end
         default: state_d = ERROR;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prev_q  <= 4'd0;
         tens_q  <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         tens_q  <= tens_d;
         ovf_q   <= ovf_d;
      end
   end
   assign tens = tens_q;
   assign ovf  = ovf_q;
   assign err  = (state_q == ERROR);
   assign trk  = (state_q == TRACK);
endmodule
